// File: rtl/spi_master_multi.sv
// rtl/spi_master_multi.sv - parametrised multi-mode SPI master with one-hot chip selects and CS-held bursts
module spi_master_multi #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 16,
    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              hold_cs,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);
    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_XFER, S_END, S_TRAIL, S_GAP} state_t;

    localparam int EW = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);
    localparam logic [EW-1:0] PEN_EDGE  = EW'(2 * DATA_W - 1);

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic              hold_q, hold_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic              sck_q, sck_d, mosi_q, mosi_d, rx_valid_q, rx_valid_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic              accept, cnt_done, fire, leading, sample_edge, drive_edge;

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    // Out-of-range selects decode to no active chip select.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] r;
        r = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (CS_W'(i) == sel) r[i] = 1'b0;
        end
        return r;
    endfunction

    assign tx_ready    = (state_q == S_IDLE) || ((state_q == S_END) && hold_q);
    assign accept      = tx_valid && tx_ready;
    assign cnt_done    = (cnt_q == '0);
    assign fire        = cnt_done && ((state_q == S_LEAD) ||
                                      ((state_q == S_XFER) && (edge_q != LAST_EDGE)));
    // edge_q counts edges already produced, so an even count means the next edge leads.
    assign leading     = ~edge_q[0];
    assign sample_edge = leading ^ cpha_q;
    assign drive_edge  = cpha_q ? leading : (!leading && (edge_q != PEN_EDGE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            edge_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            hold_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            cs_n_q     <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            hold_q     <= hold_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
            cs_n_q     <= cs_n_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        edge_d     = edge_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        hold_d     = hold_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        cs_n_d     = cs_n_q;

        if (fire) begin
            sck_d  = ~sck_q;
            edge_d = edge_q + EW'(1);
            cnt_d  = div_q;
            if (sample_edge) begin
                rx_sh_d = lsb_q ? {miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], miso};
            end
            if (drive_edge) begin
                mosi_d  = first_bit(tx_sh_q, lsb_q);
                tx_sh_d = shift_out(tx_sh_q, lsb_q);
            end
        end

        case (state_q)
            S_IDLE: begin
                sck_d = cpol;
                if (accept) begin
                    tx_sh_d = tx_data;
                    hold_d  = hold_cs;
                    cpha_d  = cpha;
                    lsb_d   = lsb_first;
                    div_d   = clk_div;
                    cnt_d   = clk_div;
                    edge_d  = '0;
                    cs_n_d  = cs_decode(cs_sel);
                    if (!cpha) begin
                        mosi_d  = first_bit(tx_data, lsb_first);
                        tx_sh_d = shift_out(tx_data, lsb_first);
                    end
                    state_d = S_LEAD;
                end
            end
            S_LEAD: begin
                if (cnt_done) state_d = S_XFER;
                else          cnt_d = cnt_q - DIV_W'(1);
            end
            S_XFER: begin
                if (cnt_done && (edge_q == LAST_EDGE)) begin
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                    state_d    = S_END;
                end else if (!cnt_done) begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            S_END: begin
                cnt_d = div_q;
                if (accept) begin
                    tx_sh_d = tx_data;
                    hold_d  = hold_cs;
                    edge_d  = '0;
                    if (!cpha_q) begin
                        mosi_d  = first_bit(tx_data, lsb_q);
                        tx_sh_d = shift_out(tx_data, lsb_q);
                    end
                    state_d = S_LEAD;
                end else begin
                    state_d = S_TRAIL;
                end
            end
            S_TRAIL: begin
                if (cnt_done) begin
                    cs_n_d  = '1;
                    cnt_d   = div_q;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_done) state_d = S_IDLE;
                else          cnt_d = cnt_q - DIV_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = (state_q != S_IDLE);
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// tb/tb_spi_master_multi.sv - self-checking bench for spi_master_multi against a bit-queue SPI slave model
module tb_spi_master_multi;
    localparam int W   = 8;
    localparam int NCS = 3;
    localparam int DW  = 16;

    typedef struct {
        logic [W-1:0]  tx;
        logic [W-1:0]  slv;
        logic          loopb;
        logic          cpol;
        logic          cpha;
        logic          lsb;
        logic [1:0]    sel;
        logic [DW-1:0] div;
        logic [W-1:0]  exp_rx;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic tx_valid, tx_ready, hold_cs, cpol, cpha, lsb_first;
    logic rx_valid, busy, sck, mosi, miso;
    logic [W-1:0] tx_data, rx_data;
    logic [1:0] cs_sel;
    logic [DW-1:0] clk_div;
    logic [NCS-1:0] cs_n;

    int checks = 0;
    int failures = 0;
    vec_t vecs[9];

    always #5 clk = ~clk;

    spi_master_multi #(.DATA_W(W), .NUM_CS(NCS), .DIV_W(DW)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .cs_sel(cs_sel), .hold_cs(hold_cs), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
        .clk_div(clk_div), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .sck(sck),
        .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    // Slave: shifts its bit queue out and records mosi on the mode's sampling edges.
    logic loop_en;
    logic slv_miso;
    logic slv_bits[$];
    logic cap_bits[$];
    int   slv_go = 0;
    int   s_go_seen = 0;
    int   s_edges = 0;
    int   s_ptr = 0;
    logic s_lead;

    assign miso = loop_en ? mosi : slv_miso;

    function automatic logic slv_bit(input int p);
        return (p < slv_bits.size()) ? slv_bits[p] : 1'b0;
    endfunction

    always @(sck or slv_go) begin
        if (slv_go != s_go_seen) begin
            s_go_seen = slv_go;
            s_edges   = 0;
            s_ptr     = 0;
            cap_bits.delete();
            slv_miso  = cpha ? 1'b0 : slv_bit(0);
        end else if (busy === 1'b1) begin
            s_lead = (sck != cpol);
            s_edges++;
            if (s_lead != cpha) cap_bits.push_back(mosi);
            if (s_lead == cpha) begin
                if (cpha) begin
                    slv_miso = slv_bit(s_ptr);
                    s_ptr++;
                end else begin
                    s_ptr++;
                    slv_miso = slv_bit(s_ptr);
                end
            end
        end
    end

    task automatic add_slv_word(input logic [W-1:0] w, input logic lsb);
        for (int i = 0; i < W; i++) slv_bits.push_back(lsb ? w[i] : w[W-1-i]);
    endtask

    function automatic logic [W-1:0] cap_word(input int off, input logic lsb);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (off + i < cap_bits.size()) begin
                if (lsb) r[i] = cap_bits[off+i];
                else     r[W-1-i] = cap_bits[off+i];
            end
        end
        return r;
    endfunction

    function automatic int xfer_len(input int t);
        return 1 + t + 2 * W * t + 1 + t + t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_xfer(input vec_t v, input string tag);
        @(negedge clk);
        cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb; clk_div = v.div;
        cs_sel = v.sel; tx_data = v.tx; hold_cs = 1'b0; loop_en = v.loopb;
        slv_bits.delete();
        add_slv_word(v.slv, v.lsb);
        slv_go++;
        repeat (2) @(negedge clk);
        check({tag, " idle_sck"}, sck, v.cpol);
        check({tag, " idle_ready"}, tx_ready, 1'b1);
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic run_xfer(input vec_t v, input string tag);
        int t, guard, busy_cyc, cs_low, cs_bad, rxp, ready_busy, last_edge, first_edge, bad_gap;
        logic [W-1:0] got_rx;
        logic [NCS-1:0] exp_cs;
        logic prev_sck, first_mosi;
        t = int'(v.div) + 1;
        for (int i = 0; i < NCS; i++) exp_cs[i] = !(i == int'(v.sel));
        start_xfer(v, tag);
        first_mosi = mosi;
        busy_cyc = 0; cs_low = 0; cs_bad = 0; rxp = 0; ready_busy = 0;
        last_edge = -1; first_edge = -1; bad_gap = 0; got_rx = '0; guard = 0;
        prev_sck = sck;
        while (busy && guard < 2000) begin
            busy_cyc++;
            if (cs_n != '1) cs_low++;
            if (cs_n != '1 && cs_n != exp_cs) cs_bad++;
            if (rx_valid) begin rxp++; got_rx = rx_data; end
            if (tx_ready) ready_busy++;
            if (sck != prev_sck) begin
                if (first_edge < 0) first_edge = busy_cyc;
                if (last_edge >= 0 && busy_cyc - last_edge != t) bad_gap++;
                last_edge = busy_cyc;
            end
            prev_sck = sck;
            @(negedge clk);
            guard++;
        end
        check({tag, " finished"}, guard < 2000, 1'b1);
        check({tag, " busy_len"}, busy_cyc, xfer_len(t) - 1);
        check({tag, " cs_low"}, cs_low, (int'(v.sel) < NCS) ? (t + 2 * W * t + 1 + t) : 0);
        check({tag, " cs_onehot"}, cs_bad, 0);
        check({tag, " rx_pulses"}, rxp, 1);
        check({tag, " rx_data"}, got_rx, v.exp_rx);
        check({tag, " sck_edges"}, s_edges, 2 * W);
        check({tag, " edge_gap"}, bad_gap, 0);
        check({tag, " lead_time"}, first_edge, t + 1);
        check({tag, " sck_after"}, sck, v.cpol);
        check({tag, " mosi_word"}, cap_word(0, v.lsb), v.tx);
        check({tag, " ready_busy"}, ready_busy, 0);
        if (!v.cpha) check({tag, " first_mosi"}, first_mosi, v.lsb ? v.tx[0] : v.tx[W-1]);
    endtask

    task automatic run_burst();
        logic [W-1:0] btx[3];
        logic [W-1:0] bsl[3];
        logic [W-1:0] rxw[$];
        int t, guard, idx, busy_cyc, cs_low, rises, ready_busy;
        logic acc, prev_low;
        btx[0] = 8'h11; btx[1] = 8'hC3; btx[2] = 8'h7E;
        bsl[0] = 8'hF0; bsl[1] = 8'h0F; bsl[2] = 8'h5A;
        t = 2;
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b1; lsb_first = 1'b0; clk_div = 16'd1; cs_sel = 2'd1; loop_en = 1'b0;
        slv_bits.delete();
        for (int i = 0; i < 3; i++) add_slv_word(bsl[i], 1'b0);
        slv_go++;
        repeat (2) @(negedge clk);
        idx = 0; tx_data = btx[0]; hold_cs = 1'b1; tx_valid = 1'b1;
        busy_cyc = 0; cs_low = 0; rises = 0; ready_busy = 0; prev_low = 1'b0; guard = 0;
        while (guard < 3000 && !(idx == 3 && !busy)) begin
            acc = tx_valid && tx_ready;
            if (busy) begin
                busy_cyc++;
                if (tx_ready) ready_busy++;
            end
            if (!cs_n[1]) cs_low++;
            if (prev_low && cs_n[1]) rises++;
            prev_low = !cs_n[1];
            if (rx_valid) rxw.push_back(rx_data);
            @(negedge clk);
            guard++;
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    tx_data = btx[idx];
                    hold_cs = (idx < 2);
                end else begin
                    tx_valid = 1'b0;
                end
            end
        end
        tx_valid = 1'b0;
        check("burst finished", guard < 3000, 1'b1);
        check("burst busy_len", busy_cyc, 3 * (t + 2 * W * t + 1) + 2 * t);
        check("burst cs_low", cs_low, 3 * (t + 2 * W * t + 1) + t);
        check("burst cs_rises", rises, 1);
        check("burst ready_busy", ready_busy, 2);
        check("burst rx_pulses", rxw.size(), 3);
        check("burst sck_edges", s_edges, 6 * W);
        for (int i = 0; i < 3 && i < rxw.size(); i++) begin
            check($sformatf("burst rx%0d", i), rxw[i], bsl[i]);
            check($sformatf("burst mosi%0d", i), cap_word(i * W, 1'b0), btx[i]);
        end
    endtask

    task automatic run_reset_abort();
        int guard, rvp;
        start_xfer(vecs[3], "abort");
        guard = 0;
        while (s_edges < 5 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("abort reached_edge5", s_edges >= 5, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("abort cs_n", cs_n, 3'b111);
        check("abort sck", sck, 1'b0);
        check("abort busy", busy, 1'b0);
        rvp = 0;
        repeat (3) begin
            @(negedge clk);
            if (rx_valid) rvp++;
        end
        check("abort no_rx_valid", rvp, 0);
        rst = 1'b0;
        run_xfer(vecs[3], "post_rst");
    endtask

    initial begin
        vec_t rv;
        // tx, slv, loop, cpol, cpha, lsb, sel, div, expected rx
        vecs[0] = '{8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd1, 8'hA5};
        vecs[1] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 16'd1, 8'h3C};
        vecs[2] = '{8'hC3, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd2, 8'h3C};
        vecs[3] = '{8'h0F, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 16'd1, 8'h3C};
        vecs[4] = '{8'h81, 8'h2C, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'd1, 8'h2C};
        vecs[5] = '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'd0, 8'h00};
        vecs[6] = '{8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 16'd0, 8'hFF};
        vecs[7] = '{8'h66, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 16'd0, 8'h99};
        vecs[8] = '{8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 16'd3, 8'h80};

        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; cs_sel = '0; hold_cs = 1'b0;
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = '0; loop_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset cs_n", cs_n, 3'b111);
        check("reset sck", sck, 1'b0);
        check("reset mosi", mosi, 1'b0);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset rx_data", rx_data, 8'h00);
        check("reset busy", busy, 1'b0);
        check("reset tx_ready", tx_ready, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

        run_burst();

        for (int i = 0; i < 16; i++) begin
            rv.tx     = 8'($urandom);
            rv.slv    = 8'($urandom);
            rv.loopb  = 1'b0;
            rv.cpol   = 1'($urandom);
            rv.cpha   = 1'($urandom);
            rv.lsb    = 1'($urandom);
            rv.sel    = 2'($urandom_range(0, 3));
            rv.div    = 16'($urandom_range(0, 3));
            rv.exp_rx = rv.slv;
            run_xfer(rv, $sformatf("rnd%0d", i));
        end

        run_reset_abort();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
Parametrised SPI master, successor to the fixed 8-bit mode-0/1 master. Adds:
- all four SPI modes, selected at run time
- configurable word width
- run-time SCK divider
- MSB/LSB-first ordering
- NUM_CS one-hot chip selects
- back-to-back burst transfers with CS held low

Sits between a register/stream front-end and the external SPI pins; one transfer engine shared by all slaves.

Parameters:
DATA_W, 8, bits per word (2..32)
NUM_CS, 4, number of active-low chip-select outputs (1..16)
DIV_W, 16, width of clk_div input

Ports:
clk  in  1  system clock
rst  in  1  async reset, active-high
tx_valid  in  1  word available for transmission
tx_ready  out  1  engine accepts word this cycle (tx_valid & tx_ready = accept)
tx_data  in  DATA_W  word to shift out
cs_sel  in  $clog2(NUM_CS) (min 1)  slave index, latched at accept
hold_cs  in  1  keep CS low after this word if another word follows, latched at accept
cpol  in  1  clock polarity, latched at accept from IDLE
cpha  in  1  clock phase, latched at accept from IDLE
lsb_first  in  1  1 = LSB shifted first, latched at accept from IDLE
clk_div  in  DIV_W  SCK half-period = clk_div+1 clk cycles, latched at accept from IDLE
rx_valid  out  1  one-cycle pulse, rx_data valid
rx_data  out  DATA_W  received word
busy  out  1  high from accept until return to IDLE
sck  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in
cs_n  out  NUM_CS  chip selects, active-low

Behaviour:
- Reset is asynchronous, active-high; clock is clk. Reset values:
  - cs_n all 1, sck 0, mosi 0
  - rx_valid 0, rx_data 0, busy 0
  - tx_ready 1, state IDLE
- All outputs registered except tx_ready, which decodes state.
- Reset asserted mid-transfer aborts immediately: CS released in the same instant, no rx_valid.
- T = clk_div+1 clk cycles (one SCK half-period). All SCK edges are spaced by exactly T.
- States:
  - IDLE:
    - tx_ready=1; sck <= cpol each cycle.
    - On accept: latch tx_data, cs_sel, hold_cs and config; go LEAD.
  - LEAD (T cycles):
    - cs_n[cs_sel] low on LEAD's first cycle.
    - CPHA=0: mosi driven with the first bit on LEAD's first cycle.
    - sck stays idle level.
  - XFER (2*DATA_W edges):
    - Odd edges are leading, even edges are trailing.
    - CPHA=0: sample miso on leading; drive next bit on trailing, except the final trailing edge.
    - CPHA=1: drive bit on leading; sample on trailing.
    - After the final edge, sck is at cpol.
  - END (1 cycle):
    - rx_data updated and rx_valid=1.
    - If hold_cs latched=1, tx_ready=1. If tx_valid is high that cycle: accept, cs_sel is ignored (same slave), go LEAD with CS kept low. Config is not re-latched.
    - Otherwise go TRAIL.
  - TRAIL (T cycles): CS low, then all cs_n high; go GAP.
  - GAP (T cycles): CS high minimum deselect time; go IDLE.
- Bit order:
  - lsb_first=0: tx bit DATA_W-1 first; first received bit lands in rx_data[DATA_W-1].
  - lsb_first=1: mirror of the above.
- cs_sel >= NUM_CS: transfer runs normally, no cs_n asserted.
- busy = (state != IDLE).
- Config inputs changing while busy: no effect.
- tx_valid with hold_cs=0 at END: not accepted; waits for IDLE.
- clk_div=0: T=1, sck toggles every clk cycle; must be functional.
- Transfer length from accept to busy fall (no hold): 1+T+2*DATA_W*T+1+T+T cycles.

Test Plan:
- Mode 0, DATA_W=8, clk_div=1, tx_data=0xA5, miso looped to mosi: rx_data=0xA5, rx_valid one pulse, cs_n[0] low for exactly T+16T+1+T cycles, 8 rising sck edges.
- Modes 1, 2, 3, slave model returning 0x3C: rx_data=0x3C in each mode; sck idles at cpol before and after; sampling edge matches mode.
- DATA_W=16, lsb_first=1, tx_data=0x8001, cs_sel=2: first mosi bit 1, last bit 1, only cs_n[2] low; slave returning 0x1234 LSB-first gives rx_data=0x1234.
- Burst of 3 words with hold_cs=1,1,0 and tx_valid continuously high: cs_n stays low across all 3 words, 3 rx_valid pulses, tx_ready high only in IDLE and the END cycles of words 1 and 2.
- clk_div=0, mode 3, 0xFF/0x00 alternating: sck period 2 clk cycles; data correct.
- rst asserted at edge 5 of a transfer: cs_n all 1 and sck 0 immediately, no rx_valid; next transfer after rst release completes correctly.
